aes128_round_key_sequencer: RTL and testbench



---
 rtl/aes128_round_key_sequencer.sv | 119 +++++++++++
 tb/tb_aes128_round_key_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_key_sequencer.sv
// Iterative AES-128 key expansion: loads a cipher key, derives round keys
// 1..10 one per clock into an 11-entry register file read by index.
module aes128_round_key_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  output logic             busy,
  output logic             keys_valid,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = ~x;
    return SBOX[{inv, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [7:0]       r_rcon;
  logic             r_busy;
  logic             r_keysValid;
  logic [KEY_W-1:0] r_rk [0:10];

  logic [3:0]       w_prevIdx;
  logic [KEY_W-1:0] w_prev;
  logic [31:0]      w_temp;
  logic [31:0]      w_n0, w_n1, w_n2, w_n3;
  logic [7:0]       w_rconNext;

  always_comb begin
    w_prevIdx  = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
    w_prev     = r_rk[w_prevIdx];
    w_temp     = subWord({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
    w_n0       = w_prev[127:96] ^ w_temp;
    w_n1       = w_prev[95:64] ^ w_n0;
    w_n2       = w_prev[63:32] ^ w_n1;
    w_n3       = w_prev[31:0] ^ w_n2;
    w_rconNext = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rcon      <= 8'h01;
      r_busy      <= 1'b0;
      r_keysValid <= 1'b0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (key_load) begin
            r_rk[0]     <= key_in;
            r_cnt       <= 4'd1;
            r_rcon      <= 8'h01;
            r_keysValid <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_EXPAND;
          end
        end
        // key_load is deliberately ignored here so a running expansion is never corrupted.
        S_EXPAND: begin
          r_rk[r_cnt] <= {w_n0, w_n1, w_n2, w_n3};
          r_rcon      <= w_rconNext;
          r_cnt       <= r_cnt + 4'd1;
          if (r_cnt == 4'(NUM_ROUNDS)) begin
            r_busy      <= 1'b0;
            r_keysValid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_idx <= 4'd10) rd_key = r_rk[rd_idx];
  end

  assign busy       = r_busy;
  assign keys_valid = r_keysValid;

endmodule

// File: tb/tb_aes128_round_key_sequencer.sv
// Directed bench for the AES-128 round-key sequencer using FIPS-197 and
// all-zero key vectors.
module tb_aes128_round_key_sequencer;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_KEY  = 128'h0;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int nCompared;
  int nMismatched;
  int busyCycles;
  bit doneSeen;

  aes128_round_key_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_load   (key_load),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a key for one rising edge (edge T); returns just after that edge.
  task automatic do_load(input logic [127:0] k);
    @(negedge clk);
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
  endtask

  // Counts busy cycles until keys_valid rises, bounded to 30 cycles.
  task automatic wait_done();
    busyCycles = 0;
    doneSeen   = 1'b0;
    for (int i = 0; i < 30 && !doneSeen; i++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (keys_valid) doneSeen = 1'b1;
    end
    nCompared++;
    if (!doneSeen) begin
      nMismatched++;
      $display("[TB] FAIL wait_done: keys_valid=%0b after 30 cycles, required 1", keys_valid);
    end
  endtask

  task automatic test_reset();
    do_load(FIPS_KEY);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    nCompared++;
    if (busy !== 1'b0 || keys_valid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_flags: busy=%0b keys_valid=%0b, required 0 0", busy, keys_valid);
    end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      nCompared++;
      if (rd_key !== 128'h0) begin
        nMismatched++;
        $display("[TB] FAIL reset_rd_key[%0d]: got %h, required 0", i, rd_key);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fips();
    bit validEarly;
    do_load(FIPS_KEY);
    busyCycles = 0;
    validEarly = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (keys_valid) validEarly = 1'b1;
    end
    nCompared++;
    if (validEarly) begin
      nMismatched++;
      $display("[TB] FAIL fips_valid_early: keys_valid seen before T+10, required 0");
    end
    @(negedge clk);
    if (busy) busyCycles++;
    nCompared++;
    if (keys_valid !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL fips_valid_T10: keys_valid=%0b, required 1", keys_valid);
    end
    nCompared++;
    if (busyCycles != 10) begin
      nMismatched++;
      $display("[TB] FAIL fips_busy_len: got %0d cycles, required 10", busyCycles);
    end
    rd_idx = 4'd0; #1;
    nCompared++;
    if (rd_key !== FIPS_KEY) begin
      nMismatched++;
      $display("[TB] FAIL fips_rk0: got %h, required %h", rd_key, FIPS_KEY);
    end
    rd_idx = 4'd1; #1;
    nCompared++;
    if (rd_key !== FIPS_RK1) begin
      nMismatched++;
      $display("[TB] FAIL fips_rk1: got %h, required %h", rd_key, FIPS_RK1);
    end
    rd_idx = 4'd2; #1;
    nCompared++;
    if (rd_key !== FIPS_RK2) begin
      nMismatched++;
      $display("[TB] FAIL fips_rk2: got %h, required %h", rd_key, FIPS_RK2);
    end
    rd_idx = 4'd10; #1;
    nCompared++;
    if (rd_key !== FIPS_RK10) begin
      nMismatched++;
      $display("[TB] FAIL fips_rk10: got %h, required %h", rd_key, FIPS_RK10);
    end
  endtask

  task automatic test_back_to_back();
    do_load(ZERO_KEY);
    nCompared++;
    if (keys_valid !== 1'b0 || busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_restart: keys_valid=%0b busy=%0b, required 0 1", keys_valid, busy);
    end
    wait_done();
    nCompared++;
    if (busyCycles != 10) begin
      nMismatched++;
      $display("[TB] FAIL b2b_busy_len: got %0d cycles, required 10", busyCycles);
    end
    rd_idx = 4'd1; #1;
    nCompared++;
    if (rd_key !== ZERO_RK1) begin
      nMismatched++;
      $display("[TB] FAIL zero_rk1: got %h, required %h", rd_key, ZERO_RK1);
    end
    rd_idx = 4'd10; #1;
    nCompared++;
    if (rd_key !== ZERO_RK10) begin
      nMismatched++;
      $display("[TB] FAIL zero_rk10: got %h, required %h", rd_key, ZERO_RK10);
    end
    rd_idx = 4'd12; #1;
    nCompared++;
    if (rd_key !== 128'h0) begin
      nMismatched++;
      $display("[TB] FAIL rd_idx12: got %h, required 0", rd_key);
    end
  endtask

  task automatic test_ignore_load();
    do_load(FIPS_KEY);
    // Edges T+1..T+3 pass; the strobe below is sampled at edge T+4.
    repeat (3) @(posedge clk);
    @(negedge clk);
    key_in   = ZERO_KEY;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    nCompared++;
    if (busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL ignore_busy: busy=%0b, required 1", busy);
    end
    wait_done();
    rd_idx = 4'd0; #1;
    nCompared++;
    if (rd_key !== FIPS_KEY) begin
      nMismatched++;
      $display("[TB] FAIL ignore_rk0: got %h, required %h", rd_key, FIPS_KEY);
    end
    rd_idx = 4'd1; #1;
    nCompared++;
    if (rd_key !== FIPS_RK1) begin
      nMismatched++;
      $display("[TB] FAIL ignore_rk1: got %h, required %h", rd_key, FIPS_RK1);
    end
    rd_idx = 4'd10; #1;
    nCompared++;
    if (rd_key !== FIPS_RK10) begin
      nMismatched++;
      $display("[TB] FAIL ignore_rk10: got %h, required %h", rd_key, FIPS_RK10);
    end
  endtask

  task automatic test_async_reset();
    do_load(ZERO_KEY);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    rd_idx = 4'd0;
    #0.5;
    nCompared++;
    if (busy !== 1'b0 || keys_valid !== 1'b0 || rd_key !== 128'h0) begin
      nMismatched++;
      $display("[TB] FAIL async_clear: busy=%0b keys_valid=%0b rk0=%h, required 0 0 0",
               busy, keys_valid, rd_key);
    end
    @(negedge clk);
    rst = 1'b0;
    do_load(FIPS_KEY);
    wait_done();
    nCompared++;
    if (busyCycles != 10) begin
      nMismatched++;
      $display("[TB] FAIL async_busy_len: got %0d cycles, required 10", busyCycles);
    end
    rd_idx = 4'd10; #1;
    nCompared++;
    if (rd_key !== FIPS_RK10) begin
      nMismatched++;
      $display("[TB] FAIL async_rk10: got %h, required %h", rd_key, FIPS_RK10);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst         = 1'b1;
    key_in      = '0;
    key_load    = 1'b0;
    rd_idx      = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_fips();
    test_back_to_back();
    test_ignore_load();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
